// File: rtl/ecp5_flash_boot_core_if.sv
// SPI flash bus between the boot core and the external flash.
//   csb  : chip select, active low          (master -> slave)
//   clk  : SPI clock, mode 0                 (master -> slave)
//   io0  : MOSI                              (master -> slave)
//   io1  : MISO, only ever driven by flash   (slave  -> master)
//   io2  : WP#,  held high by the master     (master -> slave)
//   io3  : HOLD#, held high by the master    (master -> slave)
interface ecp5_flash_boot_core_if;
    logic csb;
    logic clk;
    logic io0;
    logic io1;
    logic io2;
    logic io3;

    modport master (output csb, clk, io0, io2, io3, input io1);
    modport slave  (input csb, clk, io0, io2, io3, output io1);
endinterface

// File: rtl/ecp5_flash_boot_core.sv
// Boot-stage core for the ECP5 Boson board.
// After reset: wake the SPI flash (0xAB), wait WAKE_DELAY cycles, then issue a
// 0x03 read at FLASH_ADDR and clock in BOOT_WORDS little-endian 32-bit words.
// The words are summed (mod 2^32); when done, trap rises and led shows
// {blank_flag, checksum[6:0]}. Everything else on the board is held idle.
// Ports:
//   clk_input, wb_rst       : clock, async active-high reset
//   trap, led[7:0]          : completion flag (sticky), status
//   flash (master modport)  : SPI flash bus
//   ser_*, fpga_reset, HRAM_*, SDMMC_*, BOSON_* : unused peripherals, idle
module ecp5_flash_boot_core #(
    parameter int          CLK_DIV    = 2,
    parameter logic [23:0] FLASH_ADDR = 24'h100000,
    parameter int          BOOT_WORDS = 16,
    parameter int          WAKE_DELAY = 32
) (
    input  logic                   clk_input,
    input  logic                   wb_rst,
    output logic                   trap,
    output logic [7:0]             led,
    ecp5_flash_boot_core_if.master flash,
    output logic                   ser_tx,
    input  logic                   ser_rx,
    output logic                   ser_tx_dir,
    output logic                   ser_rx_dir,
    output logic                   fpga_reset,
    output logic                   HRAM_CK,
    output logic                   HRAM_CS,
    output logic                   HRAM_RESET,
    inout  wire                    HRAM_RWDS,
    inout  wire  [7:0]             HRAM_DQ,
    input  logic                   SDMMC_CD,
    output logic                   SDMMC_CK,
    inout  wire                    SDMMC_CMD,
    inout  wire  [3:0]             SDMMC_DATA,
    input  logic [15:0]            BOSON_DATA,
    input  logic                   BOSON_CLK,
    input  logic                   BOSON_VSYNC,
    input  logic                   BOSON_HSYNC,
    input  logic                   BOSON_VALID,
    output logic                   BOSON_RESET
);
    localparam int NBITS = BOOT_WORDS * 32;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(NBITS);
    localparam int GW    = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;

    typedef enum logic [2:0] {IDLE, WAKE, GAP, CMD, DATA, DONE} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;   // bits left in the current segment after this one
    logic [GW-1:0] gap_cnt;
    logic [31:0]   tx_sr;     // bit 31 is the bit currently on MOSI
    logic [30:0]   rx_sr;
    logic [31:0]   checksum;
    logic          blank;
    logic          sclk;
    logic          csb;

    logic          shifting, tick, bit_end, last_bit, gap_end, word_end;
    logic [31:0]   rx_nx, word;

    always_comb begin
        shifting = (state == WAKE) || (state == CMD) || (state == DATA);
        tick     = shifting && (div_cnt == DW'(CLK_DIV - 1));
        bit_end  = tick && sclk;            // falling SPI edge closes a bit
        last_bit = (bit_cnt == '0);
        gap_end  = (gap_cnt == GW'(WAKE_DELAY - 1));
        rx_nx    = {rx_sr, flash.io1};
        // Stream order is byte0..byte3, each MSB first; byte0 is the LSB.
        word     = {rx_nx[7:0], rx_nx[15:8], rx_nx[23:16], rx_nx[31:24]};
        // Word completes on the rising edge of its 32nd bit.
        word_end = (state == DATA) && tick && !sclk && (bit_cnt[4:0] == 5'd0);

        state_nx = state;
        case (state)
            IDLE:    state_nx = WAKE;
            WAKE:    if (bit_end && last_bit) state_nx = GAP;
            GAP:     if (gap_end) state_nx = CMD;
            CMD:     if (bit_end && last_bit) state_nx = DATA;
            DATA:    if (bit_end && last_bit) state_nx = DONE;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk_input or posedge wb_rst) begin
        if (wb_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk_input or posedge wb_rst) begin
        if (wb_rst) begin
            csb      <= 1'b1;
            sclk     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            checksum <= '0;
            blank    <= 1'b0;
            trap     <= 1'b0;
            led      <= '0;
        end else begin
            div_cnt <= (shifting && !tick) ? div_cnt + 1'b1 : '0;
            if (tick) sclk <= !sclk;
            if (tick && !sclk && state == DATA) rx_sr <= rx_nx[30:0];
            if (word_end) begin
                checksum <= checksum + word;
                if (bit_cnt == BW'((BOOT_WORDS - 1) * 32) && word == 32'hFFFF_FFFF)
                    blank <= 1'b1;
            end
            // MOSI only moves on the falling edge, keeping it stable while sclk is high.
            if (bit_end && !last_bit) begin
                bit_cnt <= bit_cnt - 1'b1;
                tx_sr   <= {tx_sr[30:0], 1'b0};
            end

            case (state)
                IDLE: begin
                    csb     <= 1'b0;
                    tx_sr   <= {8'hAB, 24'h0};
                    bit_cnt <= BW'(7);
                end
                WAKE: if (bit_end && last_bit) begin
                    csb     <= 1'b1;
                    tx_sr   <= '0;
                    gap_cnt <= '0;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_end) begin
                        csb     <= 1'b0;
                        tx_sr   <= {8'h03, FLASH_ADDR};
                        bit_cnt <= BW'(31);
                    end
                end
                // csb stays low: the data phase continues the read frame.
                CMD: if (bit_end && last_bit) begin
                    tx_sr   <= '0;
                    bit_cnt <= BW'(NBITS - 1);
                end
                DATA: if (bit_end && last_bit) csb <= 1'b1;
                DONE: begin
                    trap <= 1'b1;
                    led  <= {blank, checksum[6:0]};
                end
                default: ;
            endcase
        end
    end

    assign flash.csb = csb;
    assign flash.clk = sclk;
    assign flash.io0 = tx_sr[31];
    assign flash.io2 = 1'b1;
    assign flash.io3 = 1'b1;

    assign ser_tx      = 1'b1;
    assign ser_tx_dir  = 1'b1;
    assign ser_rx_dir  = 1'b0;
    assign fpga_reset  = 1'b0;
    assign HRAM_CK     = 1'b0;
    assign HRAM_CS     = 1'b1;
    assign HRAM_RESET  = 1'b0;
    assign HRAM_RWDS   = 1'bz;
    assign HRAM_DQ     = 8'bz;
    assign SDMMC_CK    = 1'b0;
    assign SDMMC_CMD   = 1'bz;
    assign SDMMC_DATA  = 4'bz;
    assign BOSON_RESET = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{ser_rx, SDMMC_CD, BOSON_DATA, BOSON_CLK,
                             BOSON_VSYNC, BOSON_HSYNC, BOSON_VALID};
endmodule

// File: tb/tb_ecp5_flash_boot_core.sv
// Bench for ecp5_flash_boot_core: two instances (16 words / CLK_DIV 2 and
// 1 word / CLK_DIV 1) each talk to a behavioural SPI flash backed by a byte
// array. Expected checksum/led come from summing the flash image directly.
module tb_ecp5_flash_boot_core;
    logic        clk_input = 1'b0;
    logic        wb_rst    = 1'b1;
    logic        ser_rx    = 1'b0;
    logic        sd_cd     = 1'b0;
    logic [15:0] boson_data = '0;
    logic        boson_clk = 1'b0, boson_vsync = 1'b0, boson_hsync = 1'b0, boson_valid = 1'b0;

    logic        trap_w [2];
    logic [7:0]  led_w  [2];
    logic [7:0]  mem    [2][64];
    int          fbits  [2][4];
    logic [31:0] fhdr   [2][4];
    int          gaps   [2][4];
    int          fidx   [2] = '{0, 0};
    int          gidx   [2] = '{0, 0};
    int          mode_viol [2] = '{0, 0};
    int          fix_viol  [2] = '{0, 0};
    int          seq_viol  [2] = '{0, 0};
    int          cyc = 0;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    always #5 clk_input = ~clk_input;
    always @(posedge clk_input) cyc++;

    // Flash byte at an absolute address; anything outside the image reads erased.
    function automatic logic flash_bit(int g, logic [23:0] a, int k);
        int         off = int'(a) - 'h100000 + k / 8;
        logic [7:0] b   = (off >= 0 && off < 64) ? mem[g][off] : 8'hFF;
        return b[7 - (k % 8)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        ecp5_flash_boot_core_if fl();
        wire        hram_rwds, sdmmc_cmd;
        wire  [7:0] hram_dq;
        wire  [3:0] sdmmc_data;
        logic ser_tx, ser_tx_dir, ser_rx_dir, fpga_reset, hram_ck, hram_cs, hram_reset;
        logic sdmmc_ck, boson_reset;
        int          rise_cnt = 0;
        int          t_rise   = 0;
        logic [31:0] hdr      = '0;
        logic        prev_io0 = 1'b0;

        ecp5_flash_boot_core #(
            .CLK_DIV((g == 0) ? 2 : 1), .FLASH_ADDR(24'h100000),
            .BOOT_WORDS((g == 0) ? 16 : 1), .WAKE_DELAY((g == 0) ? 32 : 5)
        ) dut (
            .clk_input(clk_input), .wb_rst(wb_rst), .trap(trap_w[g]), .led(led_w[g]),
            .flash(fl), .ser_tx(ser_tx), .ser_rx(ser_rx), .ser_tx_dir(ser_tx_dir),
            .ser_rx_dir(ser_rx_dir), .fpga_reset(fpga_reset), .HRAM_CK(hram_ck),
            .HRAM_CS(hram_cs), .HRAM_RESET(hram_reset), .HRAM_RWDS(hram_rwds),
            .HRAM_DQ(hram_dq), .SDMMC_CD(sd_cd), .SDMMC_CK(sdmmc_ck), .SDMMC_CMD(sdmmc_cmd),
            .SDMMC_DATA(sdmmc_data), .BOSON_DATA(boson_data), .BOSON_CLK(boson_clk),
            .BOSON_VSYNC(boson_vsync), .BOSON_HSYNC(boson_hsync), .BOSON_VALID(boson_valid),
            .BOSON_RESET(boson_reset)
        );

        // Flash: latch MOSI on rising edges, present MISO after falling edges.
        always @(posedge fl.clk) if (!fl.csb) begin
            if (rise_cnt < 32) hdr = {hdr[30:0], fl.io0};
            rise_cnt++;
        end
        always @(negedge fl.clk) if (!fl.csb && rise_cnt >= 32 && hdr[31:24] == 8'h03)
            fl.io1 = flash_bit(g, hdr[23:0], rise_cnt - 32);
        always @(posedge fl.csb) begin
            if (fidx[g] < 4) begin fbits[g][fidx[g]] = rise_cnt; fhdr[g][fidx[g]] = hdr; end
            fidx[g]++;
            rise_cnt = 0;
            hdr      = '0;
            t_rise   = cyc;
        end
        always @(negedge fl.csb) begin
            if (gidx[g] < 4) gaps[g][gidx[g]] = cyc - t_rise;
            gidx[g]++;
        end

        always @(negedge clk_input) begin
            if (fl.io0 !== prev_io0 && fl.clk === 1'b1) mode_viol[g]++;
            prev_io0 = fl.io0;
            if (ser_tx !== 1'b1 || ser_tx_dir !== 1'b1 || ser_rx_dir !== 1'b0 ||
                fpga_reset !== 1'b0 || hram_ck !== 1'b0 || hram_cs !== 1'b1 ||
                hram_reset !== 1'b0 || sdmmc_ck !== 1'b0 || boson_reset !== 1'b0 ||
                fl.io2 !== 1'b1 || fl.io3 !== 1'b1) fix_viol[g]++;
            if (!trap_w[g] && led_w[g] != 8'h00) seq_viol[g]++;
            if (trap_w[g] && (fl.clk || !fl.csb)) seq_viol[g]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_sum(int g, int nw);
        logic [31:0] s = '0;
        for (int w = 0; w < nw; w++)
            s += {mem[g][4*w+3], mem[g][4*w+2], mem[g][4*w+1], mem[g][4*w]};
        return s;
    endfunction

    function automatic logic [7:0] model_led(int g, int nw);
        logic [31:0] w0 = {mem[g][3], mem[g][2], mem[g][1], mem[g][0]};
        logic [31:0] s  = model_sum(g, nw);
        return {w0 == 32'hFFFF_FFFF, s[6:0]};
    endfunction

    task automatic load_counting();
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 4; b++) mem[0][4*w+b] = 8'((w + 1) >> (8 * b));
        mem[1][0] = 8'h78; mem[1][1] = 8'h56; mem[1][2] = 8'h34; mem[1][3] = 8'h12;
    endtask

    task automatic boot(input bit do_wait);
        bit ok = 1'b0;
        wb_rst     = 1'b1;
        boson_data = 16'($urandom);
        ser_rx     = 1'($urandom);
        repeat (3) @(posedge clk_input);
        @(negedge clk_input);
        fidx = '{0, 0};
        gidx = '{0, 0};
        check("rst_csb",  {31'd0, u[0].fl.csb}, 32'd1);
        check("rst_sclk", {30'd0, u[1].fl.clk, u[0].fl.clk}, 32'd0);
        check("rst_io0",  {31'd0, u[0].fl.io0}, 32'd0);
        check("rst_trap", {30'd0, trap_w[1], trap_w[0]}, 32'd0);
        check("rst_led",  {16'd0, led_w[1], led_w[0]}, 32'd0);
        wb_rst = 1'b0;
        if (do_wait) begin
            for (int i = 0; i < 10000; i++) begin
                @(posedge clk_input);
                if (trap_w[0] && trap_w[1]) begin ok = 1'b1; break; end
            end
            check("trap_timeout", {31'd0, ok}, 32'd1);
            repeat (20) @(posedge clk_input);
            @(negedge clk_input);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_trap0"}, {31'd0, trap_w[0]}, 32'd1);
        check({tag, "_trap1"}, {31'd0, trap_w[1]}, 32'd1);
        check({tag, "_sum0"},  u[0].dut.checksum, model_sum(0, 16));
        check({tag, "_led0"},  {24'd0, led_w[0]}, {24'd0, model_led(0, 16)});
        check({tag, "_sum1"},  u[1].dut.checksum, model_sum(1, 1));
        check({tag, "_led1"},  {24'd0, led_w[1]}, {24'd0, model_led(1, 1)});
    endtask

    initial begin
        bit ok = 1'b0;
        int target;

        // Counting image 1..16 and the byte-order word 78 56 34 12.
        load_counting();
        boot(1'b1);
        check("t1_sum0", u[0].dut.checksum, 32'd136);
        check("t1_led0", {24'd0, led_w[0]}, 32'h08);
        check("t4_sum1", u[1].dut.checksum, 32'h1234_5678);
        check("t4_led1", {24'd0, led_w[1]}, 32'h78);
        check_result("t1");
        // SPI trace of the 16-word instance.
        check("wake_bits", fbits[0][0], 32'd8);
        check("wake_op",   fhdr[0][0], 32'h0000_00AB);
        check("wake_gap",  {31'd0, gaps[0][1] >= 32}, 32'd1);
        check("rd_hdr",    fhdr[0][1], 32'h0310_0000);
        check("rd_bits",   fbits[0][1], 32'd544);
        check("frames0",   fidx[0], 32'd2);
        check("rd_bits1",  fbits[1][1], 32'd64);
        check("wake_gap1", {31'd0, gaps[1][1] >= 5}, 32'd1);
        check("frames1",   fidx[1], 32'd2);

        // Erased flash.
        for (int g = 0; g < 2; g++) for (int i = 0; i < 64; i++) mem[g][i] = 8'hFF;
        boot(1'b1);
        check("t2_sum0", u[0].dut.checksum, 32'hFFFF_FFF0);
        check("t2_led0", {24'd0, led_w[0]}, 32'hF0);
        check("t2_led1", {24'd0, led_w[1]}, 32'hFF);
        check_result("t2");

        // Random images; the middle one has a blank first word.
        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < 2; g++) for (int i = 0; i < 64; i++) mem[g][i] = 8'($urandom);
            if (r == 1) for (int g = 0; g < 2; g++) for (int i = 0; i < 4; i++) mem[g][i] = 8'hFF;
            boot(1'b1);
            check_result($sformatf("rnd%0d", r));
        end

        // Reset in the middle of the data phase, then a clean restart.
        load_counting();
        boot(1'b0);
        target = 32 + int'($urandom_range(1, 500));
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk_input);
            if (u[0].rise_cnt >= target) begin ok = 1'b1; break; end
        end
        check("mid_reach", {31'd0, ok}, 32'd1);
        #1 wb_rst = 1'b1;
        #1;
        check("mid_csb",  {31'd0, u[0].fl.csb}, 32'd1);
        check("mid_sclk", {31'd0, u[0].fl.clk}, 32'd0);
        check("mid_io0",  {31'd0, u[0].fl.io0}, 32'd0);
        check("mid_trap", {30'd0, trap_w[1], trap_w[0]}, 32'd0);
        check("mid_led",  {16'd0, led_w[1], led_w[0]}, 32'd0);
        boot(1'b1);
        check("t5_sum0", u[0].dut.checksum, 32'd136);
        check("t5_led0", {24'd0, led_w[0]}, 32'h08);
        check("t5_bits", fbits[0][1], 32'd544);

        // Whole-run monitors.
        for (int g = 0; g < 2; g++) begin
            check($sformatf("mosi_edge%0d", g), mode_viol[g], 32'd0);
            check($sformatf("idle_out%0d", g), fix_viol[g], 32'd0);
            check($sformatf("done_seq%0d", g), seq_viol[g], 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
